pll_drp_reconfig: RTL

PLL_DRP_RECONFIG -- requirements
Module: pll_drp_reconfig

---
 rtl/pll_drp_reconfig.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pll_drp_reconfig.sv
// pll_drp_reconfig: holds the PLL in reset, rewrites one table profile through DRP
// read-modify-write accesses, then releases the PLL and waits for lock.
module pll_drp_reconfig #(
   parameter int N_ENTRIES    = 9,
   parameter int RST_HOLD     = 16,
   parameter int LOCK_TIMEOUT = 65535,
   parameter int DRDY_TIMEOUT = 63
) (
   input  logic        SYSCLK,
   input  logic        RST,
   input  logic        START,
   input  logic        PROFILE,
   output logic [4:0]  TBL_ADDR,
   input  logic [36:0] TBL_DATA,
   output logic [4:0]  DADDR,
   output logic [15:0] DI,
   input  logic [15:0] DO,
   output logic        DEN,
   output logic        DWE,
   input  logic        DRDY,
   output logic        PLL_RST,
   input  logic        LOCKED,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERROR
);
   typedef enum logic [3:0] {
      INIT, HOLD, FETCH, RD, RD_WAIT, WR, WR_WAIT, NEXT, RELEASE, IDLE
   } state_t;

   localparam logic [31:0] HOLD_LAST = 32'(RST_HOLD - 1);
   localparam logic [31:0] LOCK_LAST = 32'(LOCK_TIMEOUT - 1);
   localparam logic [31:0] DRDY_LAST = 32'(DRDY_TIMEOUT - 1);
   localparam logic [3:0]  IDX_LAST  = 4'(N_ENTRIES - 1);

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [3:0]  idx_q, idx_d;
   logic        prof_q, prof_d;
   logic [36:0] ent_q, ent_d;
   logic [15:0] do_q, do_d;
   logic        err_q, err_d;
   logic        done_q, done_d;
   logic        lk1_q, lk2_q;

   always_ff @(posedge SYSCLK) begin
      if (RST) begin
         state_q <= INIT;
         cnt_q   <= '0;
         idx_q   <= '0;
         prof_q  <= 1'b0;
         ent_q   <= '0;
         do_q    <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         lk1_q   <= 1'b0;
         lk2_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         prof_q  <= prof_d;
         ent_q   <= ent_d;
         do_q    <= do_d;
         err_q   <= err_d;
         done_q  <= done_d;
         lk1_q   <= LOCKED;
         lk2_q   <= lk1_q;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      prof_d  = prof_q;
      ent_d   = ent_q;
      do_d    = do_q;
      err_d   = err_q;
      done_d  = 1'b0;
      case (state_q)
         INIT:    if (cnt_q == HOLD_LAST) state_d = RELEASE;
         HOLD:    if (cnt_q == HOLD_LAST) state_d = FETCH;
         // Address goes out in the first cycle, table data is captured at the end of the second.
         FETCH:   if (cnt_q == 32'd1) begin
                     ent_d   = TBL_DATA;
                     state_d = RD;
                  end
         RD:      state_d = RD_WAIT;
         RD_WAIT: if (DRDY) begin
                     do_d    = DO;
                     state_d = WR;
                  end else if (cnt_q == DRDY_LAST) begin
                     err_d   = 1'b1;
                     state_d = RELEASE;
                  end
         WR:      state_d = WR_WAIT;
         WR_WAIT: if (DRDY) state_d = NEXT;
                  else if (cnt_q == DRDY_LAST) begin
                     err_d   = 1'b1;
                     state_d = RELEASE;
                  end
         NEXT:    if (idx_q == IDX_LAST) state_d = RELEASE;
                  else begin
                     idx_d   = idx_q + 4'd1;
                     state_d = FETCH;
                  end
         RELEASE: if (lk2_q) begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end else if (cnt_q == LOCK_LAST) begin
                     err_d   = 1'b1;
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end
         IDLE:    if (START) begin
                     prof_d  = PROFILE;
                     err_d   = 1'b0;
                     idx_d   = '0;
                     state_d = HOLD;
                  end
         default: state_d = INIT;
      endcase
      cnt_d = (state_d != state_q) ? '0 : (&cnt_q ? cnt_q : cnt_q + 32'd1);
   end

   assign TBL_ADDR = (state_q == FETCH) ? {prof_q, idx_q} : '0;
   assign DEN      = (state_q == RD) || (state_q == WR);
   assign DWE      = (state_q == WR);
   assign DADDR    = DEN ? ent_q[36:32] : '0;
   assign DI       = DWE ? ((do_q & ent_q[31:16]) | (ent_q[15:0] & ~ent_q[31:16])) : '0;
   assign PLL_RST  = (state_q != RELEASE) && (state_q != IDLE);
   assign BUSY     = (state_q != IDLE);
   assign DONE     = done_q;
   assign ERROR    = err_q;
endmodule
